// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operands and opcode in,
// handshake, result and flags out.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, co, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, co, ovf, zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Small ALU: single-cycle logic/arith ops plus an unsigned shift-add multiply
// that iterates one multiplier bit per clock. Result and flags hold between done pulses.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_multicycle_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_ADD   = 3'b010,
        OP_RSVD  = 3'b011,
        OP_NOR   = 3'b100,
        OP_MULTU = 3'b101,
        OP_SUB   = 3'b110,
        OP_SLT   = 3'b111
    } op_t;

    state_t             state, state_next;
    logic               accept, is_mul, mul_last;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_step;
    logic [WIDTH:0]     step_sum, add_sum, sub_sum;
    logic               add_ovf, sub_ovf;
    logic [WIDTH-1:0]   alu_res, result_q, result_hi_q;
    logic               alu_co, alu_ovf, co_q, ovf_q, done_q;

    assign is_mul   = (op_t'(bus.op) == OP_MULTU);
    assign accept   = (state == S_IDLE) && bus.start;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = is_mul ? S_MUL : S_FIN;
            S_MUL:   if (mul_last)  state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_MUL);
    end

    // Single-cycle datapath, evaluated on the live operands at the accepting edge.
    always_comb begin
        add_sum = {1'b0, bus.a} + {1'b0, bus.b};
        sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.a[WIDTH-1]);
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ovf = 1'b0;
        case (op_t'(bus.op))
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_co  = add_sum[WIDTH];
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_co  = sub_sum[WIDTH];
                alu_ovf = sub_ovf;
            end
            OP_SLT:  alu_res = WIDTH'(sub_sum[WIDTH-1] ^ sub_ovf);
            default: alu_res = '0;
        endcase
    end

    // prod holds {accumulator, remaining multiplier bits}; each step adds and shifts right.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
        prod_step = {step_sum, prod[WIDTH-1:1]};
    end

    // NOTE: multiply partials carry no reset; they are always reloaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod  <= {{WIDTH{1'b0}}, bus.b};
            mcand <= bus.a;
            cnt   <= '0;
        end else if (state == S_MUL) begin
            prod  <= prod_step;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state == S_FIN);
            if (accept && !is_mul) begin
                result_q    <= alu_res;
                result_hi_q <= '0;
                co_q        <= alu_co;
                ovf_q       <= alu_ovf;
            end else if ((state == S_MUL) && mul_last) begin
                {result_hi_q, result_q} <= prod_step;
                co_q                    <= 1'b0;
                ovf_q                   <= 1'b0;
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): directed vectors push expected
// responses; a negedge monitor pops and compares on every done pulse.
module tb_alu_multicycle;
    localparam int W = 32;
    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_RSVD = 3'b011,
                           OP_NOR = 3'b100, OP_MULTU = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         co;
        logic         ovf;
        logic         zero;
        int           done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] last_res, last_hi;

    alu_multicycle_if #(.WIDTH(W)) bus ();
    alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done expected=no_done result=%0h (cycle %0d)",
                         bus.result, cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"},    bus.result,    mon_e.res);
                check({mon_e.name, "_result_hi"}, bus.result_hi, mon_e.hi);
                check({mon_e.name, "_co"},        bus.co,        mon_e.co);
                check({mon_e.name, "_ovf"},       bus.ovf,       mon_e.ovf);
                check({mon_e.name, "_zero"},      bus.zero,      mon_e.zero);
                check({mon_e.name, "_done_cycle"}, cyc,          mon_e.done_cyc);
                last_res = mon_e.res;
                last_hi  = mon_e.hi;
            end
        end
    end

    // Called at a negedge; returns at the first negedge after the accepting edge with start dropped.
    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] ia, ib,
                         input logic [W-1:0] er, eh, input logic eco, eovf,
                         input int lat, input bit push);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk);
        #1;
        if (push) begin
            e.name = name; e.res = er; e.hi = eh; e.co = eco; e.ovf = eovf;
            e.zero = (er == '0);
            e.done_cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic alu_op(input string name, input logic [2:0] o, input logic [W-1:0] ia, ib,
                          input logic [W-1:0] er, input logic eco, eovf);
        issue(name, o, ia, ib, er, '0, eco, eovf, 1, 1'b1);
        check({name, "_busy_low"}, bus.busy, 1'b0);
        drain();
    endtask

    task automatic mul_op(input string name, input logic [W-1:0] ia, ib, er, eh);
        issue(name, OP_MULTU, ia, ib, er, eh, 1'b0, 1'b0, W + 1, 1'b1);
        drain();
    endtask

    // Waits (bounded) for all expected responses, then confirms outputs hold afterwards.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
            sb.delete();
        end else begin
            @(negedge clk);
            @(negedge clk);
            check("hold_result",    bus.result,    last_res);
            check("hold_result_hi", bus.result_hi, last_hi);
        end
    endtask

    initial begin
        int nbusy;
        bus.start = 1'b0;
        bus.op    = OP_AND;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_done",      bus.done,      1'b0);
        check("rst_result",    bus.result,    32'h0);
        check("rst_result_hi", bus.result_hi, 32'h0);
        check("rst_co",        bus.co,        1'b0);
        check("rst_ovf",       bus.ovf,       1'b0);
        check("rst_zero",      bus.zero,      1'b1);

        // First start issued together with reset release must be accepted at the next edge.
        rst = 1'b0;
        alu_op("add_wrap",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        alu_op("add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        alu_op("add_co_ovf", OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        alu_op("sub_borrow", OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        alu_op("sub_plain",  OP_SUB, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0);
        alu_op("sub_ovf",    OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        alu_op("slt_neg",    OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        alu_op("slt_pos",    OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        alu_op("slt_min",    OP_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        alu_op("and",        OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
        alu_op("or",         OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0);
        alu_op("nor_ones",   OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        alu_op("nor_zero",   OP_NOR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        alu_op("reserved",   OP_RSVD, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b0, 1'b0);

        // start held across the FIN edge: only one operation may be accepted.
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 32'd10;
        bus.b     = 32'd20;
        @(posedge clk);
        #1;
        sb.push_back('{name: "add_fin_hold", res: 32'd30, hi: 32'd0, co: 1'b0, ovf: 1'b0,
                       zero: 1'b0, done_cyc: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Full-scale multiply with busy-window length.
        issue("mul_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE,
              1'b0, 1'b0, W + 1, 1'b1);
        nbusy = 0;
        while (bus.busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
        check("mul_max_busy_cycles", nbusy, 32);
        drain();

        mul_op("mul_small", 32'd3,        32'd5,        32'd15,        32'd0);
        mul_op("mul_zero",  32'd0,        32'hDEAD_BEEF, 32'd0,        32'd0);
        mul_op("mul_lo0",   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);

        // Restarts and operand changes during busy must not disturb the latched multiply.
        issue("mul_latched", OP_MULTU, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 32'h0000_0001,
              1'b0, 1'b0, W + 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.start = 1'b1;
            bus.op    = (i % 2 == 0) ? OP_MULTU : OP_ADD;
            bus.a     = 32'hFFFF_0000 + i;
            bus.b     = 32'h0000_FFFF - i;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
        end
        drain();

        // Abort a multiply by reset 10 cycles in; a start coincident with reset is ignored.
        alu_op("add_pre_abort", OP_ADD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue("mul_abort", OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, '0, '0, 1'b0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        check("abort_busy",      bus.busy,      1'b0);
        check("abort_done",      bus.done,      1'b0);
        check("abort_result",    bus.result,    32'h0);
        check("abort_result_hi", bus.result_hi, 32'h0);
        check("abort_co",        bus.co,        1'b0);
        check("abort_ovf",       bus.ovf,       1'b0);
        check("abort_zero",      bus.zero,      1'b1);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", bus.busy, 1'b0);
        last_res = '0;
        last_hi  = '0;
        alu_op("add_post_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width (legal range 4..64).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; SHALL be sampled only while idle (busy=0).
REQ-005 op  input  3  operation code, sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while a multiply is iterating.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  WIDTH  result, low word for multiply.
REQ-011 result_hi  output  WIDTH  multiply high word; 0 for other ops.
REQ-012 co  output  1  carry-out of ADD/SUB.
REQ-013 ovf  output  1  signed overflow of ADD/SUB.
REQ-014 zero  output  1  result==0 (low word only).

Function
REQ-015 op encoding SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 101 MULTU, 011 reserved.
REQ-016 States SHALL be IDLE, MUL, FIN; IDLE->FIN on start with single-cycle op; IDLE->MUL on start with MULTU; MUL->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-017 Single-cycle ops: start at edge k -> result/flags registered at edge k, done=1 for exactly the cycle after edge k+1... namely done SHALL be high during cycle following edge k+1 only (latency 2 edges, 1 bubble-free accept every 2 cycles).
REQ-018 MULTU SHALL be unsigned shift-add, one bit per cycle; busy=1 from edge k through edge k+WIDTH; done=1 after edge k+WIDTH+1 for one cycle; product = a*b as 2*WIDTH bits {result_hi,result}.
REQ-019 ADD: result=a+b mod 2^WIDTH, co=carry out of MSB, ovf=(a[MSB]==b[MSB])&&(result[MSB]!=a[MSB]).
REQ-020 SUB: result=a+~b+1, co=carry out (1 means no borrow), ovf=(a[MSB]!=b[MSB])&&(result[MSB]!=a[MSB]).
REQ-021 SLT: result=1 if a<b signed (sub sign XOR sub ovf), else 0; co=0, ovf=0.
REQ-022 AND/OR/NOR/MULTU/reserved: co=0, ovf=0; reserved op SHALL give result=0, done pulse as single-cycle op.
REQ-023 start while busy=1 or state FIN SHALL be ignored; operands latched at accept SHALL not change with input changes mid-operation.
REQ-024 result, result_hi, co, ovf, zero SHALL hold their values from the last done until the next done; they SHALL not glitch through intermediate multiply partials (partials kept in internal registers).
REQ-025 zero SHALL be derived from registered result and update together with it.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, result=0, result_hi=0, co=0, ovf=0, zero=1.
REQ-027 rst during MUL or FIN SHALL abort the operation with no done pulse; start coincident with rst SHALL be ignored.
REQ-028 First start SHALL be accepted at the first edge with rst=0.

Verification (WIDTH=32)
REQ-029 ADD a=0xFFFFFFFF b=1 -> result=0, co=1, ovf=0, zero=1, done one cycle.
REQ-030 ADD a=0x7FFFFFFF b=1 -> result=0x80000000, ovf=1, co=0; SUB a=5 b=7 -> result=0xFFFFFFFE, co=0.
REQ-031 SLT a=0xFFFFFFFF b=1 -> result=1; SLT a=1 b=0xFFFFFFFF -> result=0.
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001, busy high 32 cycles, done 33 edges after accept.
REQ-033 start pulsed repeatedly with different operands during MULTU busy -> ignored, product of originally latched operands returned.
REQ-034 rst asserted 10 cycles into MULTU -> no done, all outputs at reset values next cycle, next start accepted normally.
